// File: rtl/systolic_matmul_nxn.sv
// Output-stationary NxN systolic matrix multiplier with run-time inner dimension K.
// Beats enter through per-row/per-column skew lines; results leave one C row per handshake.
module systolic_matmul_nxn #(
    parameter int N      = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int K_W    = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_col,
    input  logic [N*DATA_W-1:0]   b_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*ACC_W-1:0]    out_row,
    output logic [IDX_W-1:0]      out_row_idx,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    localparam int FL_W = $clog2(2 * N);

    // in_valid/in_ready and out_valid/out_ready: a transfer happens on a rising edge
    // where both are high; valid holds its payload stable until the transfer.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               state_q;
    logic [K_W-1:0]       k_len_q;
    logic [K_W-1:0]       beat_cnt_q;
    logic [FL_W-1:0]      flush_cnt_q;
    logic [IDX_W-1:0]     row_q;
    logic                 busy_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 done_q;
    logic [N*ACC_W-1:0]   out_row_q;

    logic                 accept;
    logic                 clear_acc;
    logic                 out_hs;

    logic [DATA_W-1:0]    a_edge [N];
    logic [DATA_W-1:0]    b_edge [N];
    logic [DATA_W-1:0]    a_fwd  [N][N-1];
    logic [DATA_W-1:0]    b_fwd  [N-1][N];
    logic [ACC_W-1:0]     acc_w  [N][N];
    logic [N*ACC_W-1:0]   acc_row [N];

    assign accept    = in_valid & in_ready_q;
    assign clear_acc = (state_q == S_IDLE) & start;
    assign out_hs    = out_valid_q & out_ready;

    assign busy        = busy_q;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_row_idx = row_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            out_row_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_len_q    <= k_len;
                        beat_cnt_q <= '0;
                        row_q      <= '0;
                        busy_q     <= 1'b1;
                        if (k_len == '0) begin
                            // Accumulators clear on this edge, so row 0 is known to be zero.
                            state_q     <= S_DRAIN;
                            out_valid_q <= 1'b1;
                            out_row_q   <= '0;
                        end else begin
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (beat_cnt_q == k_len_q - K_W'(1)) begin
                            state_q     <= S_FLUSH;
                            in_ready_q  <= 1'b0;
                            flush_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + K_W'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    // Row 0 is complete well before the far corner PE, so it can be latched now.
                    if (flush_cnt_q == FL_W'(2 * N - 2)) begin
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        row_q       <= '0;
                        out_row_q   <= acc_row[0];
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FL_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        if (row_q == IDX_W'(N - 1)) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            row_q     <= row_q + IDX_W'(1);
                            out_row_q <= acc_row[row_q + IDX_W'(1)];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DATA_W-1:0] a_inj;
        logic [DATA_W-1:0] b_inj;
        assign a_inj = accept ? a_col[gi*DATA_W +: DATA_W] : '0;
        assign b_inj = accept ? b_row[gi*DATA_W +: DATA_W] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = a_inj;
            assign b_edge[gi] = b_inj;
        end else begin : g_delay
            logic [DATA_W-1:0] a_sk_q [gi];
            logic [DATA_W-1:0] b_sk_q [gi];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < gi; k++) begin
                        a_sk_q[k] <= '0;
                        b_sk_q[k] <= '0;
                    end
                end else begin
                    a_sk_q[0] <= a_inj;
                    b_sk_q[0] <= b_inj;
                    for (int k = 1; k < gi; k++) begin
                        a_sk_q[k] <= a_sk_q[k-1];
                        b_sk_q[k] <= b_sk_q[k-1];
                    end
                end
            end
            assign a_edge[gi] = a_sk_q[gi-1];
            assign b_edge[gi] = b_sk_q[gi-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [DATA_W-1:0]   a_in;
            logic [DATA_W-1:0]   b_in;
            logic [DATA_W-1:0]   a_q;
            logic [DATA_W-1:0]   b_q;
            logic [ACC_W-1:0]    acc_q;
            logic [2*DATA_W-1:0] prod;

            if (gj == 0) begin : g_a_edge
                assign a_in = a_edge[gi];
            end else begin : g_a_chain
                assign a_in = a_fwd[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in = b_edge[gj];
            end else begin : g_b_chain
                assign b_in = b_fwd[gi-1][gj];
            end
            if (gj < N - 1) begin : g_a_out
                assign a_fwd[gi][gj] = a_q;
            end
            if (gi < N - 1) begin : g_b_out
                assign b_fwd[gi][gj] = b_q;
            end

            assign prod = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
            assign acc_w[gi][gj] = acc_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    acc_q <= clear_acc ? '0 : acc_q + ACC_W'(prod);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            acc_row[i] = '0;
            for (int j = 0; j < N; j++) begin
                acc_row[i][j*ACC_W +: ACC_W] = acc_w[i][j];
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Directed bench for systolic_matmul_nxn: three instances (2x2/16b, 2x2/8b wrap, 4x4/16b)
// share control stimulus; sel picks which instance is started and observed.
module tb_systolic_matmul_nxn;

  logic clk;
  logic rst;
  logic start;
  logic [7:0] k_len;
  logic in_valid;
  logic out_ready;
  logic [63:0] a_bus;
  logic [63:0] b_bus;
  int sel;

  logic st2, st8, st4;
  logic busy2, busy8, busy4;
  logic rdy2, rdy8, rdy4;
  logic ov2, ov8, ov4;
  logic done2, done8, done4;
  logic [63:0] row2;
  logic [31:0] row8;
  logic [127:0] row4;
  logic [0:0] idx2, idx8;
  logic [1:0] idx4;
  logic [1:0] dbg2, dbg8, dbg4;

  logic obs_busy, obs_in_ready, obs_valid, obs_done;
  logic [127:0] obs_row;
  logic [1:0] obs_idx, obs_state;

  logic [127:0] exp_q[$];
  logic [127:0] got_row_q[$];
  logic [1:0] got_idx_q[$];

  int n_checks;
  int n_fail;

  assign st2 = start & (sel == 0);
  assign st8 = start & (sel == 1);
  assign st4 = start & (sel == 2);

  systolic_matmul_nxn #(.N(2), .DATA_W(16), .ACC_W(32), .K_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(st2), .k_len(k_len), .busy(busy2),
    .in_valid(in_valid), .in_ready(rdy2), .a_col(a_bus[31:0]), .b_row(b_bus[31:0]),
    .out_valid(ov2), .out_ready(out_ready), .out_row(row2), .out_row_idx(idx2),
    .done(done2), .dbg_state_o(dbg2)
  );

  systolic_matmul_nxn #(.N(2), .DATA_W(8), .ACC_W(16), .K_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .k_len(k_len), .busy(busy8),
    .in_valid(in_valid), .in_ready(rdy8), .a_col(a_bus[15:0]), .b_row(b_bus[15:0]),
    .out_valid(ov8), .out_ready(out_ready), .out_row(row8), .out_row_idx(idx8),
    .done(done8), .dbg_state_o(dbg8)
  );

  systolic_matmul_nxn #(.N(4), .DATA_W(16), .ACC_W(32), .K_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .k_len(k_len), .busy(busy4),
    .in_valid(in_valid), .in_ready(rdy4), .a_col(a_bus), .b_row(b_bus),
    .out_valid(ov4), .out_ready(out_ready), .out_row(row4), .out_row_idx(idx4),
    .done(done4), .dbg_state_o(dbg4)
  );

  always_comb begin
    obs_busy = busy2; obs_in_ready = rdy2; obs_valid = ov2; obs_done = done2;
    obs_row = {64'd0, row2}; obs_idx = {1'b0, idx2}; obs_state = dbg2;
    if (sel == 1) begin
      obs_busy = busy8; obs_in_ready = rdy8; obs_valid = ov8; obs_done = done8;
      obs_row = {96'd0, row8}; obs_idx = {1'b0, idx8}; obs_state = dbg8;
    end else if (sel == 2) begin
      obs_busy = busy4; obs_in_ready = rdy4; obs_valid = ov4; obs_done = done4;
      obs_row = row4; obs_idx = idx4; obs_state = dbg4;
    end
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: all are entered and left at a falling edge
  task automatic start_run(input int s, input logic [7:0] k);
    sel = s;
    start = 1'b1;
    k_len = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    a_bus = a;
    b_bus = b;
    @(negedge clk);
    in_valid = 1'b0;
    a_bus = '0;
    b_bus = '0;
  endtask

  // Cycle 1 is the falling edge right after the last accepted beat (or after start for k=0).
  task automatic collect(input int stall, output int first_v, output int n_done,
                         output int n_changes, output logic post_busy, output logic post_ov);
    int cyc;
    int stall_left;
    int done_at;
    logic [127:0] held;
    first_v = -1; n_done = 0; n_changes = 0; post_busy = 1'b1; post_ov = 1'b1;
    stall_left = stall; done_at = -1; cyc = 1; held = '0;
    got_row_q.delete();
    got_idx_q.delete();
    while (cyc < 300 && (done_at < 0 || cyc <= done_at + 1)) begin
      if (obs_valid && first_v < 0) begin
        first_v = cyc;
        held = obs_row;
      end
      if (obs_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        if (obs_row !== held) n_changes++;
      end else begin
        out_ready = 1'b1;
      end
      if (obs_valid && out_ready) begin
        got_row_q.push_back(obs_row);
        got_idx_q.push_back(obs_idx);
      end
      if (obs_done === 1'b1) begin
        n_done++;
        if (done_at < 0) begin
          done_at = cyc;
          post_busy = obs_busy;
          post_ov = obs_valid;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", s, obs_busy); end
      n_checks++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 0", s, obs_in_ready); end
      n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", s, obs_valid); end
      n_checks++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", s, obs_done); end
      n_checks++; if (obs_row !== 128'd0) begin n_fail++; $display("FAIL reset_out_row[%0d]: got %h want 0", s, obs_row); end
      n_checks++; if (obs_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx[%0d]: got %0d want 0", s, obs_idx); end
      n_checks++; if (obs_state !== 2'd0) begin n_fail++; $display("FAIL reset_state[%0d]: got %0d want 0", s, obs_state); end
    end
    rst = 1'b0;
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int fv, nd, nc;
    logic pb, po;
    exp_q.delete();
    exp_q.push_back({64'd0, 32'd22, 32'd19});
    exp_q.push_back({64'd0, 32'd50, 32'd43});
    start_run(0, 8'd2);
    n_checks++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b want 1", obs_in_ready); end
    n_checks++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", obs_busy); end
    beat(64'h0003_0001, 64'h0006_0005, 0);
    beat(64'h0004_0002, 64'h0008_0007, 0);
    collect(0, fv, nd, nc, pb, po);
    n_checks++; if (fv !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", fv); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    n_checks++; if (pb !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", pb); end
    n_checks++; if (po !== 1'b0) begin n_fail++; $display("FAIL basic_valid_at_done: got %b want 0", po); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL basic_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
      n_checks++; if (got_idx_q[r] !== 2'(r)) begin n_fail++; $display("FAIL basic_idx%0d: got %0d want %0d", r, got_idx_q[r], r); end
    end
  endtask

  task automatic test_bubbles;
    int fv, nd, nc;
    logic pb, po;
    exp_q.delete();
    exp_q.push_back({64'd0, 32'd22, 32'd19});
    exp_q.push_back({64'd0, 32'd50, 32'd43});
    start_run(0, 8'd2);
    beat(64'h0003_0001, 64'h0006_0005, 0);
    beat(64'h0004_0002, 64'h0008_0007, 2);
    collect(0, fv, nd, nc, pb, po);
    n_checks++; if (fv !== 4) begin n_fail++; $display("FAIL bubble_latency: got %0d want 4", fv); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL bubble_done_count: got %0d want 1", nd); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bubble_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL bubble_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
    end
  endtask

  task automatic test_backpressure;
    int fv, nd, nc;
    logic pb, po;
    exp_q.delete();
    exp_q.push_back({64'd0, 32'd22, 32'd19});
    exp_q.push_back({64'd0, 32'd50, 32'd43});
    start_run(0, 8'd2);
    beat(64'h0003_0001, 64'h0006_0005, 0);
    beat(64'h0004_0002, 64'h0008_0007, 0);
    collect(5, fv, nd, nc, pb, po);
    n_checks++; if (nc !== 0) begin n_fail++; $display("FAIL stall_row_changes: got %0d want 0", nc); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL stall_done_count: got %0d want 1", nd); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL stall_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
      n_checks++; if (got_idx_q[r] !== 2'(r)) begin n_fail++; $display("FAIL stall_idx%0d: got %0d want %0d", r, got_idx_q[r], r); end
    end
  endtask

  task automatic test_reset_mid_load;
    int fv, nd, nc;
    logic pb, po;
    start_run(0, 8'd3);
    beat(64'h0000_7777_9999, 64'h0000_5555_AAAA, 0);
    n_checks++; if (obs_state !== 2'd1) begin n_fail++; $display("FAIL midload_state: got %0d want 1", obs_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL midload_busy: got %b want 0", obs_busy); end
    n_checks++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL midload_in_ready: got %b want 0", obs_in_ready); end
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL midload_out_valid: got %b want 0", obs_valid); end
    n_checks++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL midload_done: got %b want 0", obs_done); end
    exp_q.delete();
    exp_q.push_back({64'd0, 32'd4, 32'd3});
    exp_q.push_back(128'd0);
    start_run(0, 8'd1);
    start = 1'b1;
    k_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_start_in_ready: got %b want 1", obs_in_ready); end
    beat(64'h0000_0001, 64'h0004_0003, 0);
    collect(0, fv, nd, nc, pb, po);
    n_checks++; if (fv !== 4) begin n_fail++; $display("FAIL rerun_latency: got %0d want 4", fv); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL rerun_done_count: got %0d want 1", nd); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rerun_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL rerun_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
    end
  endtask

  task automatic test_wrap;
    int fv, nd, nc;
    logic pb, po;
    exp_q.delete();
    exp_q.push_back({96'd0, 16'd64514, 16'd64514});
    exp_q.push_back({96'd0, 16'd64514, 16'd64514});
    start_run(1, 8'd2);
    beat(64'h0000_FFFF, 64'h0000_FFFF, 0);
    beat(64'h0000_FFFF, 64'h0000_FFFF, 0);
    collect(0, fv, nd, nc, pb, po);
    n_checks++; if (fv !== 4) begin n_fail++; $display("FAIL wrap_latency: got %0d want 4", fv); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL wrap_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
    end
  endtask

  task automatic test_n4;
    int fv, nd, nc;
    logic pb, po;
    logic [15:0] ma [4][4];
    logic [15:0] mb [4][4];
    logic [31:0] mc;
    logic [127:0] row;
    logic [63:0] av, bv;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = 16'($urandom_range(0, 65535));
        mb[i][j] = 16'($urandom_range(0, 65535));
      end
    end
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      row = '0;
      for (int j = 0; j < 4; j++) begin
        mc = '0;
        for (int k = 0; k < 4; k++) mc = mc + ({16'd0, ma[r][k]} * {16'd0, mb[k][j]});
        row[j*32 +: 32] = mc;
      end
      exp_q.push_back(row);
    end
    start_run(2, 8'd4);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        av[i*16 +: 16] = ma[i][k];
        bv[i*16 +: 16] = mb[k][i];
      end
      beat(av, bv, 0);
    end
    collect(0, fv, nd, nc, pb, po);
    n_checks++; if (fv !== 8) begin n_fail++; $display("FAIL n4_latency: got %0d want 8", fv); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL n4_done_count: got %0d want 1", nd); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL n4_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL n4_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
      n_checks++; if (got_idx_q[r] !== 2'(r)) begin n_fail++; $display("FAIL n4_idx%0d: got %0d want %0d", r, got_idx_q[r], r); end
    end

    exp_q.delete();
    for (int r = 0; r < 4; r++) exp_q.push_back(128'd0);
    start_run(2, 8'd0);
    collect(0, fv, nd, nc, pb, po);
    n_checks++; if (fv !== 1) begin n_fail++; $display("FAIL k0_latency: got %0d want 1", fv); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL k0_done_count: got %0d want 1", nd); end
    n_checks++; if (got_row_q.size() != exp_q.size()) begin n_fail++; $display("FAIL k0_row_count: got %0d want %0d", got_row_q.size(), exp_q.size()); end
    for (int r = 0; r < exp_q.size() && r < got_row_q.size(); r++) begin
      n_checks++; if (got_row_q[r] !== exp_q[r]) begin n_fail++; $display("FAIL k0_row%0d: got %h want %h", r, got_row_q[r], exp_q[r]); end
      n_checks++; if (got_idx_q[r] !== 2'(r)) begin n_fail++; $display("FAIL k0_idx%0d: got %0d want %0d", r, got_idx_q[r], r); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_bus = '0;
    b_bus = '0;
    sel = 0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_bubbles;
    test_backpressure;
    test_reset_mid_load;
    test_wrap;
    test_n4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
